sap3_mem_arbiter: RTL and testbench

//   Shares the single external memory interface (MAR load strobe, RAM write strobe, 16-bit bus,
//   8-bit read-data return) between two requesters: port 0 = SAP-3 core, port 1 = host loader/debug.

---
 rtl/sap3_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_sap3_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sap3_mem_arbiter.sv
// Two-port memory arbiter for the SAP-3 external memory interface.
// Each access runs as an address phase followed by a write or timed read phase, then a one-cycle ack.
module sap3_mem_arbiter #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned READ_WAIT  = 2,
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              owner,
   output logic              mem_mar_we,
   output logic              mem_ram_we,
   output logic [ADDR_W-1:0] mem_bus,
   output logic              mem_bus_oe,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_WAIT - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_WR   = 3'd2;
   localparam logic [2:0] S_RD   = 3'd3;
   localparam logic [2:0] S_ACK  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              last_q, last_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic              busy_q, busy_d;
   logic              mar_q, mar_d;
   logic              ram_q, ram_d;
   logic [ADDR_W-1:0] bus_q, bus_d;
   logic              oe_q, oe_d;
   logic              pick1;

   // Port 1 wins when alone, or on a tie when round-robin says port 0 went last.
   always_comb begin
      pick1 = req1 & (~req0 | ((FIXED_PRIO == 0) & ~last_q));
   end

   // Next state, then every registered output derived from the next state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      last_d  = last_q;
      rdata_d = rdata_q;

      case (state_q)
         S_IDLE: begin
            if (req0 | req1) begin
               owner_d = pick1;
               we_d    = pick1 ? we1 : we0;
               addr_d  = pick1 ? addr1 : addr0;
               wdata_d = pick1 ? wdata1 : wdata0;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            cnt_d   = '0;
            state_d = we_q ? S_WR : S_RD;
         end
         S_WR: state_d = S_ACK;
         S_RD: begin
            if (cnt_q == RD_LAST) begin
               rdata_d = mem_rdata;
               state_d = S_ACK;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_ACK: begin
            last_d  = owner_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      mar_d  = (state_d == S_ADDR);
      ram_d  = (state_d == S_WR);
      oe_d   = mar_d | ram_d;
      bus_d  = mar_d ? addr_d : (ram_d ? ADDR_W'(wdata_d) : '0);
      ack0_d = (state_d == S_ACK) & ~owner_d;
      ack1_d = (state_d == S_ACK) & owner_d;
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         owner_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         last_q  <= 1'b1;
         rdata_q <= '0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         busy_q  <= 1'b0;
         mar_q   <= 1'b0;
         ram_q   <= 1'b0;
         bus_q   <= '0;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         last_q  <= last_d;
         rdata_q <= rdata_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         busy_q  <= busy_d;
         mar_q   <= mar_d;
         ram_q   <= ram_d;
         bus_q   <= bus_d;
         oe_q    <= oe_d;
      end
   end

   assign ack0       = ack0_q;
   assign ack1       = ack1_q;
   assign rdata      = rdata_q;
   assign busy       = busy_q;
   assign owner      = owner_q;
   assign mem_mar_we = mar_q;
   assign mem_ram_we = ram_q;
   assign mem_bus    = bus_q;
   assign mem_bus_oe = oe_q;

endmodule

// File: tb/tb_sap3_mem_arbiter.sv
// Bench for sap3_mem_arbiter: directed scenarios plus random traffic checked against a
// timeline model (grant cycle + fixed offsets per access type).
module tb_sap3_mem_arbiter;

   localparam int RW = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        req0, req1, we0, we1;
   logic [15:0] addr0, addr1;
   logic [7:0]  wdata0, wdata1, mem_rdata;
   logic        ack0, ack1, busy, owner, mem_mar_we, mem_ram_we, mem_bus_oe;
   logic [15:0] mem_bus;
   logic [7:0]  rdata;

   logic        f_req0, f_req1;
   logic        f_ack0, f_ack1, f_busy, f_owner, f_mar, f_ram, f_oe;
   logic [15:0] f_bus;
   logic [7:0]  f_rdata;

   sap3_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .READ_WAIT(RW), .FIXED_PRIO(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy), .owner(owner),
      .mem_mar_we(mem_mar_we), .mem_ram_we(mem_ram_we),
      .mem_bus(mem_bus), .mem_bus_oe(mem_bus_oe), .mem_rdata(mem_rdata)
   );

   sap3_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .READ_WAIT(RW), .FIXED_PRIO(1)) dut_fix (
      .clk(clk), .rst_n(rst_n),
      .req0(f_req0), .req1(f_req1), .we0(1'b1), .we1(1'b1),
      .addr0(16'h0A0A), .addr1(16'h0B0B), .wdata0(8'h0A), .wdata1(8'h0B),
      .ack0(f_ack0), .ack1(f_ack1), .rdata(f_rdata), .busy(f_busy), .owner(f_owner),
      .mem_mar_we(f_mar), .mem_ram_we(f_ram),
      .mem_bus(f_bus), .mem_bus_oe(f_oe), .mem_rdata(8'h00)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: one in-flight access described by its grant cycle and attributes.
   bit          m_act, m_port, m_we, m_last, m_owner;
   int          m_start, m_ackd;
   logic [15:0] m_addr;
   logic [7:0]  m_wdata, m_rdata;
   bit          ack_seen0, ack_seen1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_act   = 1'b0;
      m_last  = 1'b1;
      m_owner = 1'b0;
      m_rdata = 8'h00;
   endtask

   function automatic bit inflight_at(input int c);
      int d;
      d = c - m_start;
      return m_act && d >= 1 && d <= m_ackd;
   endfunction

   task automatic check_cycle();
      int          d;
      bit          infl, e_mar, e_ram;
      logic [15:0] e_bus;
      if (!rst_n) model_reset();
      d     = cyc - m_start;
      infl  = inflight_at(cyc);
      e_mar = infl && d == 1;
      e_ram = infl && m_we && d == 2;
      e_bus = e_mar ? m_addr : (e_ram ? {8'h00, m_wdata} : 16'h0000);
      ack_seen0 = infl && d == m_ackd && !m_port;
      ack_seen1 = infl && d == m_ackd && m_port;
      chk("mar_we", 32'(mem_mar_we), 32'(e_mar));
      chk("ram_we", 32'(mem_ram_we), 32'(e_ram));
      chk("bus",    32'(mem_bus),    32'(e_bus));
      chk("bus_oe", 32'(mem_bus_oe), 32'(e_mar || e_ram));
      chk("ack0",   32'(ack0),       32'(ack_seen0));
      chk("ack1",   32'(ack1),       32'(ack_seen1));
      chk("busy",   32'(busy),       32'(infl));
      chk("owner",  32'(owner),      32'(m_owner));
      chk("rdata",  32'(rdata),      32'(m_rdata));
      if (rst_n) begin
         if (infl && !m_we && d == m_ackd - 1) m_rdata = mem_rdata;
         if (infl && d == m_ackd) m_last = m_port;
         if (!infl && (req0 || req1)) begin
            m_port  = (req0 && req1) ? !m_last : req1;
            m_act   = 1'b1;
            m_start = cyc;
            m_we    = m_port ? we1 : we0;
            m_addr  = m_port ? addr1 : addr0;
            m_wdata = m_port ? wdata1 : wdata0;
            m_ackd  = m_we ? 3 : 2 + RW;
            m_owner = m_port;
         end
      end
   endtask

   // Check the cycle just ending, then advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic port_drive(input bit acked, input bit mine, inout logic r, inout logic w,
                             inout logic [15:0] a, inout logic [7:0] wd);
      bit fresh;
      fresh = 1'b0;
      if (r) begin
         if (acked) begin
            if ($urandom_range(1, 0) == 0) r = 1'b0;
            else fresh = 1'b1;
         end else if (mine && $urandom_range(9, 0) == 0) begin
            r = 1'b0;
         end
      end else if ($urandom_range(3, 0) == 0) begin
         fresh = 1'b1;
      end
      if (fresh) begin
         r  = 1'b1;
         w  = 1'($urandom);
         a  = 16'($urandom);
         wd = 8'($urandom);
      end
   endtask

   initial begin
      int n0, n1, lat;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
      f_req0 = 0; f_req1 = 0;
      model_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // Single write from port 0.
      we0 = 1; addr0 = 16'h1234; wdata0 = 8'hA5; req0 = 1;
      repeat (3) tick();
      req0 = 0;
      repeat (2) tick();

      // Single read from port 1; memory data changes after the sample point.
      we1 = 0; addr1 = 16'h00FF; mem_rdata = 8'h5C; req1 = 1;
      repeat (4) tick();
      req1 = 0; mem_rdata = 8'h33;
      repeat (3) tick();
      chk("t2_rdata_held", 32'(rdata), 32'h5C);

      // Both ports hold write requests: round-robin alternation.
      we0 = 1; we1 = 1; addr0 = 16'h2000; addr1 = 16'h3000; wdata0 = 8'h01; wdata1 = 8'h02;
      req0 = 1; req1 = 1;
      repeat (16) tick();
      req0 = 0; req1 = 0;
      repeat (8) tick();

      // Asynchronous reset during the address phase of a write.
      we0 = 1; addr0 = 16'hBEEF; wdata0 = 8'h11; req0 = 1;
      tick();
      #1;
      chk("t5_mar_pre", 32'(mem_mar_we), 32'h1);
      chk("t5_bus_pre", 32'(mem_bus), 32'hBEEF);
      rst_n = 1'b0;
      #1;
      chk("t5_mar",   32'(mem_mar_we), 32'h0);
      chk("t5_ram",   32'(mem_ram_we), 32'h0);
      chk("t5_bus",   32'(mem_bus),    32'h0);
      chk("t5_oe",    32'(mem_bus_oe), 32'h0);
      chk("t5_busy",  32'(busy),       32'h0);
      chk("t5_acks",  32'({ack1, ack0}), 32'h0);
      chk("t5_rdata", 32'(rdata),      32'h0);
      req0 = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      we1 = 0; addr1 = 16'h0042; mem_rdata = 8'h9D; req1 = 1;
      repeat (4) tick();
      req1 = 0;
      repeat (2) tick();

      // Fixed priority instance: port 1 starves while port 0 holds its request.
      f_req0 = 1; f_req1 = 1; n0 = 0; n1 = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         #1;
         if (f_ack0) n0++;
         chk("fix_starve", 32'(f_ack1), 32'h0);
      end
      chk("fix_ack0_count", 32'(n0), 32'd3);
      f_req0 = 0; lat = 0;
      for (int i = 0; i < 8 && lat == 0; i++) begin
         tick();
         #1;
         if (f_ack1) lat = i + 1;
      end
      chk("fix_ack1_latency", 32'(lat), 32'd3);
      f_req1 = 0;
      repeat (3) tick();

      // Random traffic, including requests dropped mid-transaction.
      for (int n = 0; n < 1500; n++) begin
         tick();
         mem_rdata = 8'($urandom);
         port_drive(ack_seen0, inflight_at(cyc) && !m_port, req0, we0, addr0, wdata0);
         port_drive(ack_seen1, inflight_at(cyc) && m_port,  req1, we1, addr1, wdata1);
      end
      req0 = 0; req1 = 0;
      repeat (8) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
